// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the Mini-MIPS core.
//   - ALU opcode constants, as decoded by the decode stage and consumed by
//     the ALU.
//   - State encoding of the execute-stage exception controller.
//   - A helper that identifies opcodes whose overflow flag is meaningful.
// No ports: this file only holds types, constants and functions.
// ---------------------------------------------------------------------------
package mips_pkg;

   // ALU opcodes. SUB shares the low bits of ADD, so the adder is selected
   // by the low nibble and bit 4 picks subtraction.
   localparam logic [4:0] ALU_ADD = 5'h00;
   localparam logic [4:0] ALU_SUB = 5'h10;
   localparam logic [4:0] ALU_AND = 5'h01;
   localparam logic [4:0] ALU_OR  = 5'h02;
   localparam logic [4:0] ALU_NOT = 5'h03;
   localparam logic [4:0] ALU_XOR = 5'h04;
   localparam logic [4:0] ALU_SLL = 5'h05;
   localparam logic [4:0] ALU_SRL = 5'h06;
   localparam logic [4:0] ALU_SRA = 5'h07;
   localparam logic [4:0] ALU_EQ  = 5'h08;
   localparam logic [4:0] ALU_NE  = 5'h09;
   localparam logic [4:0] ALU_LT  = 5'h0a;
   localparam logic [4:0] ALU_GT  = 5'h0b;
   localparam logic [4:0] ALU_LE  = 5'h0c;
   localparam logic [4:0] ALU_GE  = 5'h0d;
   localparam logic [4:0] ALU_LTU = 5'h0e;
   localparam logic [4:0] ALU_GTU = 5'h0f;

   // Execute-stage controller states. RUN is the normal flowing state;
   // TRAP holds the stage closed until the handler acknowledges.
   typedef enum logic {
      EX_RUN  = 1'b0,
      EX_TRAP = 1'b1
   } ex_state_t;

   // The ALU only defines its overflow output for ADD and SUB; for every
   // other opcode it may drive X, so the flag must be masked with this.
   function automatic logic is_add_sub(input logic [4:0] op);
      return (op == ALU_ADD) || (op == ALU_SUB);
   endfunction

endpackage

// File: rtl/ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// ex_pipe_reg
// One-entry valid/ready register slice used twice by ex_stage (operand slice
// and result slice).
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, empties the slice and
//                   zeroes the payload
//   flush      in   synchronous clear, same effect as rst; takes priority
//                   over a load on the same edge
//   in_valid   in   upstream offers a payload
//   in_ready   out  slice can take a payload this cycle (empty, or the
//                   current entry leaves on the same edge)
//   in_data    in   payload, WIDTH bits
//   out_valid  out  slice holds a payload
//   out_ready  in   downstream takes the payload this cycle
//   out_data   out  registered payload
// ---------------------------------------------------------------------------
module ex_pipe_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             valid_q;
   logic [WIDTH-1:0] data_q;

   // The slice advances whenever it is empty or its entry is being taken,
   // which lets a drain and a refill happen on the same edge.
   assign in_ready  = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;

   // Payload only updates when a real entry arrives, so the outputs stay
   // stable across bubbles and downstream sees no spurious changes.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (in_ready) begin
         valid_q <= in_valid;
         if (in_valid) begin
            data_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
// Execute-stage controller of the Mini-MIPS core. Registers decoded operands
// (OPR slice), presents them to the external combinational ALU, and captures
// the ALU result into the result slice (RES) for the memory stage. A trapping
// ADD/SUB overflow squashes the faulting instruction, raises a precise
// exception and closes the stage until the handler acknowledges it.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   id_valid / id_ready      handshake with decode
//   id_rs_val, id_rt_val     operands (rs also carries the shift amount)
//   id_imm, id_use_imm       raw immediate and its select
//   id_alu_op                ALU opcode (mips_pkg)
//   id_rd, id_wb_en          destination register and write enable
//   id_trap_ovf              overflow traps (ADD/SUB vs ADDU/SUBU)
//   id_pc                    instruction PC
//   alu_in1, alu_in2,
//   alu_op, alu_imm          operands and controls driven to the ALU
//   alu_out, alu_overflow    ALU result and overflow flag
//   ex_valid / ex_ready      handshake with the memory stage
//   ex_result, ex_rd,
//   ex_wb_en, ex_pc          registered result fields
//   exc_ovf, exc_pc          pending overflow exception and faulting PC
//   exc_ack                  handler acknowledge
// ---------------------------------------------------------------------------
module ex_stage
   import mips_pkg::*;
#(
   parameter int BUS_WIDTH      = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,

   input  logic                      id_valid,
   output logic                      id_ready,
   input  logic [BUS_WIDTH-1:0]      id_rs_val,
   input  logic [BUS_WIDTH-1:0]      id_rt_val,
   input  logic [15:0]               id_imm,
   input  logic                      id_use_imm,
   input  logic [4:0]                id_alu_op,
   input  logic [REG_ADDR_WIDTH-1:0] id_rd,
   input  logic                      id_wb_en,
   input  logic                      id_trap_ovf,
   input  logic [BUS_WIDTH-1:0]      id_pc,

   output logic [BUS_WIDTH-1:0]      alu_in1,
   output logic [BUS_WIDTH-1:0]      alu_in2,
   output logic [4:0]                alu_op,
   output logic                      alu_imm,
   input  logic [BUS_WIDTH-1:0]      alu_out,
   input  logic                      alu_overflow,

   output logic                      ex_valid,
   input  logic                      ex_ready,
   output logic [BUS_WIDTH-1:0]      ex_result,
   output logic [REG_ADDR_WIDTH-1:0] ex_rd,
   output logic                      ex_wb_en,
   output logic [BUS_WIDTH-1:0]      ex_pc,

   output logic                      exc_ovf,
   output logic [BUS_WIDTH-1:0]      exc_pc,
   input  logic                      exc_ack
);

   // Operand slice payload: rs, rt, imm, use_imm, op, rd, wb_en, trap_ovf, pc.
   localparam int OPR_W = 3 * BUS_WIDTH + 16 + 1 + 5 + REG_ADDR_WIDTH + 1 + 1;
   // Result slice payload: result, rd, wb_en, pc.
   localparam int RES_W = 2 * BUS_WIDTH + REG_ADDR_WIDTH + 1;

   ex_state_t                 state_q;
   ex_state_t                 state_d;
   logic [BUS_WIDTH-1:0]      exc_pc_q;
   logic                      exc_pc_load;

   logic                      opr_in_valid;
   logic                      opr_adv;
   logic                      opr_valid;
   logic [OPR_W-1:0]          opr_in_data;
   logic [OPR_W-1:0]          opr_data;

   logic [BUS_WIDTH-1:0]      opr_rs;
   logic [BUS_WIDTH-1:0]      opr_rt;
   logic [15:0]               opr_imm;
   logic                      opr_use_imm;
   logic [4:0]                opr_alu_op;
   logic [REG_ADDR_WIDTH-1:0] opr_rd;
   logic                      opr_wb_en;
   logic                      opr_trap_ovf;
   logic [BUS_WIDTH-1:0]      opr_pc;

   logic                      res_in_valid;
   logic                      res_adv;
   logic [RES_W-1:0]          res_in_data;
   logic [RES_W-1:0]          res_data;

   logic                      trap;
   logic                      trap_take;

   // -----------------------------------------------------------------------
   // Operand slice. Decode is only accepted while running; the slice is
   // emptied on the edge a trap is taken so the faulting instruction (and
   // anything arriving with it) never reaches the result slice.
   // -----------------------------------------------------------------------
   assign id_ready     = (state_q == EX_RUN) && opr_adv && !rst;
   assign opr_in_valid = id_valid && id_ready;
   assign opr_in_data  = {id_rs_val, id_rt_val, id_imm, id_use_imm, id_alu_op,
                          id_rd, id_wb_en, id_trap_ovf, id_pc};

   ex_pipe_reg #(.WIDTH(OPR_W)) u_opr (
      .clk       (clk),
      .rst       (rst),
      .flush     (trap_take),
      .in_valid  (opr_in_valid),
      .in_ready  (opr_adv),
      .in_data   (opr_in_data),
      .out_valid (opr_valid),
      .out_ready (res_adv),
      .out_data  (opr_data)
   );

   assign {opr_rs, opr_rt, opr_imm, opr_use_imm, opr_alu_op,
           opr_rd, opr_wb_en, opr_trap_ovf, opr_pc} = opr_data;

   // -----------------------------------------------------------------------
   // ALU drive. The immediate is passed raw in the low half; the ALU applies
   // its own sign or zero extension depending on the opcode.
   // -----------------------------------------------------------------------
   assign alu_in1 = opr_rs;
   assign alu_in2 = opr_use_imm ? {{(BUS_WIDTH-16){1'b0}}, opr_imm} : opr_rt;
   assign alu_op  = opr_alu_op;
   assign alu_imm = opr_use_imm;

   // The opcode gate comes first so an undefined overflow flag on non-adder
   // opcodes can never leak into the trap decision.
   assign trap      = opr_valid && opr_trap_ovf && is_add_sub(opr_alu_op)
                      && alu_overflow;
   assign trap_take = trap && res_adv && (state_q == EX_RUN);

   // -----------------------------------------------------------------------
   // Result slice. A trapping instruction is presented as a bubble, so an
   // older result already held here still drains on the trap edge.
   // -----------------------------------------------------------------------
   assign res_in_valid = opr_valid && !trap;
   assign res_in_data  = {alu_out, opr_rd, opr_wb_en, opr_pc};

   ex_pipe_reg #(.WIDTH(RES_W)) u_res (
      .clk       (clk),
      .rst       (rst),
      .flush     (1'b0),
      .in_valid  (res_in_valid),
      .in_ready  (res_adv),
      .in_data   (res_in_data),
      .out_valid (ex_valid),
      .out_ready (ex_ready),
      .out_data  (res_data)
   );

   assign {ex_result, ex_rd, ex_wb_en, ex_pc} = res_data;

   // -----------------------------------------------------------------------
   // Exception controller state and faulting-PC register. Reset always
   // returns to RUN so no exception survives a reset.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= EX_RUN;
         exc_pc_q <= '0;
      end else begin
         state_q <= state_d;
         if (exc_pc_load) begin
            exc_pc_q <= opr_pc;
         end
      end
   end

   // -----------------------------------------------------------------------
   // Next-state logic. A trap is only taken on an edge where the result
   // slice can move, so the older instruction ahead of it is not lost.
   // An acknowledge while running has no meaning and is ignored.
   // -----------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      exc_pc_load = 1'b0;
      unique case (state_q)
         EX_RUN: begin
            if (trap_take) begin
               state_d     = EX_TRAP;
               exc_pc_load = 1'b1;
            end
         end
         EX_TRAP: begin
            if (exc_ack) begin
               state_d = EX_RUN;
            end
         end
         default: begin
            state_d = EX_RUN;
         end
      endcase
   end

   assign exc_ovf = (state_q == EX_TRAP);
   assign exc_pc  = exc_pc_q;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage
// Self-checking bench for ex_stage. Provides a behavioural ALU on the ALU
// ports, drives directed instruction sequences, and keeps an in-order
// scoreboard of expected results built from the instruction fields at the
// moment decode hands them over.
// ---------------------------------------------------------------------------
module tb_ex_stage;
   import mips_pkg::*;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_rs_val;
   logic [31:0] id_rt_val;
   logic [15:0] id_imm;
   logic        id_use_imm;
   logic [4:0]  id_alu_op;
   logic [4:0]  id_rd;
   logic        id_wb_en;
   logic        id_trap_ovf;
   logic [31:0] id_pc;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [4:0]  alu_op;
   logic        alu_imm;
   logic [31:0] alu_out;
   logic        alu_overflow;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_result;
   logic [4:0]  ex_rd;
   logic        ex_wb_en;
   logic [31:0] ex_pc;
   logic        exc_ovf;
   logic [31:0] exc_pc;
   logic        exc_ack;

   int vectors;
   int miscompares;

   typedef struct {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        wb;
      logic [31:0] pc;
      logic        trap;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic        prev_exc;
   logic        hold_pending;
   logic [31:0] hold_result;
   logic [4:0]  hold_rd;
   logic [31:0] hold_pc;
   int          mon_idx;
   logic        mon_exp_ready;

   ex_stage #(.BUS_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_ready     (id_ready),
      .id_rs_val    (id_rs_val),
      .id_rt_val    (id_rt_val),
      .id_imm       (id_imm),
      .id_use_imm   (id_use_imm),
      .id_alu_op    (id_alu_op),
      .id_rd        (id_rd),
      .id_wb_en     (id_wb_en),
      .id_trap_ovf  (id_trap_ovf),
      .id_pc        (id_pc),
      .alu_in1      (alu_in1),
      .alu_in2      (alu_in2),
      .alu_op       (alu_op),
      .alu_imm      (alu_imm),
      .alu_out      (alu_out),
      .alu_overflow (alu_overflow),
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .ex_result    (ex_result),
      .ex_rd        (ex_rd),
      .ex_wb_en     (ex_wb_en),
      .ex_pc        (ex_pc),
      .exc_ovf      (exc_ovf),
      .exc_pc       (exc_pc),
      .exc_ack      (exc_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Second operand as the ALU sees it: logical ops zero-extend an
   // immediate, everything else sign-extends it.
   function automatic logic [31:0] ext_b(input logic [4:0] op, input logic [31:0] b,
                                         input logic imm);
      logic [31:0] r;
      if (!imm) r = b;
      else if (op == ALU_AND || op == ALU_OR || op == ALU_XOR) r = {16'h0000, b[15:0]};
      else r = {{16{b[15]}}, b[15:0]};
      return r;
   endfunction

   function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic imm);
      logic [31:0] bb;
      logic [31:0] r;
      bb = ext_b(op, b, imm);
      case (op)
         ALU_ADD: r = a + bb;
         ALU_SUB: r = a - bb;
         ALU_AND: r = a & bb;
         ALU_OR:  r = a | bb;
         ALU_NOT: r = ~a;
         ALU_XOR: r = a ^ bb;
         ALU_SLL: r = bb << a[4:0];
         ALU_SRL: r = bb >> a[4:0];
         ALU_SRA: r = $unsigned($signed(bb) >>> a[4:0]);
         ALU_EQ:  r = {31'b0, a == bb};
         ALU_NE:  r = {31'b0, a != bb};
         ALU_LT:  r = {31'b0, $signed(a) <  $signed(bb)};
         ALU_GT:  r = {31'b0, $signed(a) >  $signed(bb)};
         ALU_LE:  r = {31'b0, $signed(a) <= $signed(bb)};
         ALU_GE:  r = {31'b0, $signed(a) >= $signed(bb)};
         ALU_LTU: r = {31'b0, a <  bb};
         ALU_GTU: r = {31'b0, a >  bb};
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   function automatic logic ovf_fn(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic imm);
      logic [31:0] bb;
      logic [31:0] s;
      bb = ext_b(op, b, imm);
      if (op == ALU_ADD) begin
         s = a + bb;
         return (a[31] == bb[31]) && (s[31] != a[31]);
      end
      s = a - bb;
      return (a[31] != bb[31]) && (s[31] != a[31]);
   endfunction

   // Behavioural ALU. Overflow is undefined for non-adder opcodes; it is
   // driven high there so any failure to mask it becomes visible.
   always_comb begin
      alu_out      = alu_fn(alu_op, alu_in1, alu_in2, alu_imm);
      alu_overflow = is_add_sub(alu_op) ? ovf_fn(alu_op, alu_in1, alu_in2, alu_imm) : 1'b1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Offers one instruction to decode and returns 1 time unit after the
   // edge that accepted it, with id_valid dropped.
   task automatic applyStimulus(input logic [4:0] op, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [15:0] imm,
                                input logic use_imm, input logic [4:0] rd,
                                input logic wb, input logic trap, input logic [31:0] pc);
      logic accepted;
      id_alu_op   = op;
      id_rs_val   = rs;
      id_rt_val   = rt;
      id_imm      = imm;
      id_use_imm  = use_imm;
      id_rd       = rd;
      id_wb_en    = wb;
      id_trap_ovf = trap;
      id_pc       = pc;
      id_valid    = 1'b1;
      accepted    = 1'b0;
      for (int n = 0; n < 50 && !accepted; n++) begin
         @(negedge clk);
         if (id_ready) accepted = 1'b1;
      end
      if (!accepted) checkOutput("accept_timeout", {31'b0, id_ready}, 32'd1);
      else @(posedge clk);
      #1;
      id_valid = 1'b0;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard and per-cycle compare. Sampled on the falling edge, when
   // everything that will act on the next rising edge is settled.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev_exc     = 1'b0;
         hold_pending = 1'b0;
      end else begin
         // A newly raised exception must belong to the oldest trapping
         // instruction still in flight; it and anything younger are squashed.
         if (exc_ovf && !prev_exc) begin
            mon_idx = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
               if (mon_idx < 0 && exp_q[i].trap) mon_idx = i;
            end
            if (mon_idx < 0) checkOutput("exc_without_trap", {31'b0, exc_ovf}, 32'd0);
            else begin
               checkOutput("exc_pc", exc_pc, exp_q[mon_idx].pc);
               while (exp_q.size() > mon_idx) void'(exp_q.pop_back());
            end
         end
         prev_exc = exc_ovf;

         // Decode is blocked while an exception is pending, or when both
         // slots hold an instruction and nothing leaves this cycle.
         mon_exp_ready = !exc_ovf && !(exp_q.size() >= 2 && !ex_ready);
         checkOutput("id_ready", {31'b0, id_ready}, {31'b0, mon_exp_ready});

         if (hold_pending) begin
            checkOutput("hold_valid", {31'b0, ex_valid}, 32'd1);
            checkOutput("hold_result", ex_result, hold_result);
            checkOutput("hold_rd", {27'b0, ex_rd}, {27'b0, hold_rd});
            checkOutput("hold_pc", ex_pc, hold_pc);
         end

         if (ex_valid && ex_ready) begin
            if (exp_q.size() == 0) checkOutput("spurious_ex_valid", {31'b0, ex_valid}, 32'd0);
            else begin
               mon_e = exp_q.pop_front();
               if (mon_e.trap) checkOutput("trap_result_delivered", {31'b0, ex_valid}, 32'd0);
               else begin
                  checkOutput("ex_result", ex_result, mon_e.result);
                  checkOutput("ex_rd", {27'b0, ex_rd}, {27'b0, mon_e.rd});
                  checkOutput("ex_wb_en", {31'b0, ex_wb_en}, {31'b0, mon_e.wb});
                  checkOutput("ex_pc", ex_pc, mon_e.pc);
               end
            end
         end

         hold_pending = ex_valid && !ex_ready;
         hold_result  = ex_result;
         hold_rd      = ex_rd;
         hold_pc      = ex_pc;

         if (id_valid && id_ready) begin
            mon_e.result = alu_fn(id_alu_op, id_rs_val,
                                  id_use_imm ? {16'h0000, id_imm} : id_rt_val, id_use_imm);
            mon_e.rd     = id_rd;
            mon_e.wb     = id_wb_en;
            mon_e.pc     = id_pc;
            mon_e.trap   = id_trap_ovf && is_add_sub(id_alu_op) &&
                           ovf_fn(id_alu_op, id_rs_val,
                                  id_use_imm ? {16'h0000, id_imm} : id_rt_val, id_use_imm);
            exp_q.push_back(mon_e);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   localparam logic [4:0] STREAM_OPS [8] = '{ALU_OR, ALU_XOR, ALU_SLL, ALU_SRA,
                                              ALU_SUB, ALU_LTU, ALU_NOT, ALU_AND};

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      id_valid    = 1'b0;
      id_rs_val   = '0;
      id_rt_val   = '0;
      id_imm      = '0;
      id_use_imm  = 1'b0;
      id_alu_op   = ALU_ADD;
      id_rd       = '0;
      id_wb_en    = 1'b0;
      id_trap_ovf = 1'b0;
      id_pc       = '0;
      ex_ready    = 1'b1;
      exc_ack     = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_id_ready", {31'b0, id_ready}, 32'd0);
      checkOutput("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
      checkOutput("rst_ex_result", ex_result, 32'd0);
      checkOutput("rst_ex_rd", {27'b0, ex_rd}, 32'd0);
      checkOutput("rst_ex_wb_en", {31'b0, ex_wb_en}, 32'd0);
      checkOutput("rst_ex_pc", ex_pc, 32'd0);
      checkOutput("rst_exc_ovf", {31'b0, exc_ovf}, 32'd0);
      checkOutput("rst_exc_pc", exc_pc, 32'd0);
      checkOutput("rst_alu_op", {27'b0, alu_op}, {27'b0, ALU_ADD});
      checkOutput("rst_alu_in1", alu_in1, 32'd0);
      checkOutput("rst_alu_in2", alu_in2, 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("idle_id_ready", {31'b0, id_ready}, 32'd1);

      // ADD 3+4: result visible one edge after acceptance
      applyStimulus(ALU_ADD, 32'd3, 32'd4, 16'h0, 1'b0, 5'd1, 1'b1, 1'b1, 32'h0000_0010);
      checkOutput("add_not_yet_valid", {31'b0, ex_valid}, 32'd0);
      nextCycle();
      checkOutput("add_ex_valid", {31'b0, ex_valid}, 32'd1);
      checkOutput("add_ex_result", ex_result, 32'd7);
      checkOutput("add_exc_ovf", {31'b0, exc_ovf}, 32'd0);

      // ADDI 5 + 0xFFFF: immediate passed raw, ALU sign-extends
      applyStimulus(ALU_ADD, 32'd5, 32'hDEAD_BEEF, 16'hFFFF, 1'b1, 5'd2, 1'b1, 1'b1, 32'h0000_0014);
      checkOutput("addi_alu_in1", alu_in1, 32'd5);
      checkOutput("addi_alu_in2", alu_in2, 32'h0000_FFFF);
      checkOutput("addi_alu_imm", {31'b0, alu_imm}, 32'd1);
      nextCycle();
      checkOutput("addi_ex_result", ex_result, 32'd4);

      // Back-to-back stream of eight with a three-cycle downstream stall
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               applyStimulus(STREAM_OPS[i], 32'h0101_0101 * (i + 1) + 32'd3,
                             32'hF0F0_1234 ^ (32'h1111 * i), 16'(16'h0100 + i),
                             (i == 5), 5'(8 + i), 1'b1, 1'b0, 32'h0000_0100 + 32'(4 * i));
            end
         end
         begin
            repeat (3) @(posedge clk);
            #1 ex_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 ex_ready = 1'b1;
         end
      join
      repeat (4) nextCycle();

      // Trapping ADD preceded by a normal one
      applyStimulus(ALU_ADD, 32'd10, 32'd20, 16'h0, 1'b0, 5'd3, 1'b1, 1'b1, 32'h0000_003C);
      applyStimulus(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 16'h0, 1'b0, 5'd4, 1'b1, 1'b1, 32'h0000_0040);
      checkOutput("pre_trap_ex_valid", {31'b0, ex_valid}, 32'd1);
      checkOutput("pre_trap_ex_pc", ex_pc, 32'h0000_003C);
      checkOutput("pre_trap_ex_result", ex_result, 32'd30);
      nextCycle();
      checkOutput("trap_exc_ovf", {31'b0, exc_ovf}, 32'd1);
      checkOutput("trap_exc_pc", exc_pc, 32'h0000_0040);
      checkOutput("trap_ex_valid", {31'b0, ex_valid}, 32'd0);
      checkOutput("trap_id_ready", {31'b0, id_ready}, 32'd0);
      repeat (3) nextCycle();
      checkOutput("trap_hold_exc", {31'b0, exc_ovf}, 32'd1);
      checkOutput("trap_hold_id_ready", {31'b0, id_ready}, 32'd0);
      exc_ack = 1'b1;
      nextCycle();
      exc_ack = 1'b0;
      checkOutput("ack_exc_ovf", {31'b0, exc_ovf}, 32'd0);
      checkOutput("ack_id_ready", {31'b0, id_ready}, 32'd1);

      // Same overflow without trapping, with a stray acknowledge in RUN
      exc_ack = 1'b1;
      applyStimulus(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 16'h0, 1'b0, 5'd5, 1'b1, 1'b0, 32'h0000_0044);
      nextCycle();
      exc_ack = 1'b0;
      checkOutput("addu_ex_result", ex_result, 32'h8000_0000);
      checkOutput("addu_exc_ovf", {31'b0, exc_ovf}, 32'd0);

      // Signed compare with trap enabled: overflow flag must be ignored
      applyStimulus(ALU_LT, 32'hFFFF_FFFF, 32'd1, 16'h0, 1'b0, 5'd6, 1'b1, 1'b1, 32'h0000_0048);
      nextCycle();
      checkOutput("slt_ex_result", ex_result, 32'd1);
      checkOutput("slt_exc_ovf", {31'b0, exc_ovf}, 32'd0);

      // Reset while in TRAP
      applyStimulus(ALU_SUB, 32'h8000_0000, 32'd1, 16'h0, 1'b0, 5'd7, 1'b1, 1'b1, 32'h0000_0050);
      nextCycle();
      checkOutput("trap2_exc_ovf", {31'b0, exc_ovf}, 32'd1);
      checkOutput("trap2_exc_pc", exc_pc, 32'h0000_0050);
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      #1;
      checkOutput("rst_trap_exc_ovf", {31'b0, exc_ovf}, 32'd0);
      checkOutput("rst_trap_ex_valid", {31'b0, ex_valid}, 32'd0);
      checkOutput("rst_trap_id_ready", {31'b0, id_ready}, 32'd1);

      // Reset with both slots full
      ex_ready = 1'b0;
      applyStimulus(ALU_OR, 32'h0000_00F0, 32'h0000_000F, 16'h0, 1'b0, 5'd9, 1'b1, 1'b0, 32'h0000_0060);
      applyStimulus(ALU_XOR, 32'h0000_00FF, 32'h0000_000F, 16'h0, 1'b0, 5'd10, 1'b1, 1'b0, 32'h0000_0064);
      checkOutput("full_id_ready", {31'b0, id_ready}, 32'd0);
      checkOutput("full_ex_result", ex_result, 32'h0000_00FF);
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      ex_ready = 1'b1;
      #1;
      checkOutput("rst_full_ex_valid", {31'b0, ex_valid}, 32'd0);
      checkOutput("rst_full_ex_result", ex_result, 32'd0);
      checkOutput("rst_full_id_ready", {31'b0, id_ready}, 32'd1);

      // Stage still works after reset
      applyStimulus(ALU_ADD, 32'd1, 32'd1, 16'h0, 1'b0, 5'd11, 1'b1, 1'b1, 32'h0000_0070);
      nextCycle();
      checkOutput("post_rst_result", ex_result, 32'd2);
      repeat (3) nextCycle();
      checkOutput("queue_drained", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute-stage controller for the Mini-MIPS core. It sits directly upstream of the ALU. It accepts decoded instructions from decode over a valid/ready handshake and registers the ALU operands. It drives the combinational `alu` and captures its result and overflow into a result register for the memory stage. On a trapping ADD/SUB overflow it raises a precise exception and stalls until the exception is acknowledged.

## Interface
- `BUS_WIDTH`, 32, datapath width
- `REG_ADDR_WIDTH`, 5, destination register index width

- `clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `id_valid` in 1: decode offers an instruction
- `id_ready` out 1: stage accepts this cycle
- `id_rs_val` in BUS_WIDTH: rs operand, or shift amount in bits [4:0]
- `id_rt_val` in BUS_WIDTH: rt operand, or shift source
- `id_imm` in 16: raw immediate
- `id_use_imm` in 1: select immediate as second operand
- `id_alu_op` in 5: ALU opcode from the shared package
- `id_rd` in REG_ADDR_WIDTH: destination register
- `id_wb_en` in 1: instruction writes a register
- `id_trap_ovf` in 1: overflow traps (add/sub versus addu/subu)
- `id_pc` in BUS_WIDTH: instruction PC
- `alu_in1`, `alu_in2` out BUS_WIDTH: ALU operands
- `alu_op` out 5: ALU opcode
- `alu_imm` out 1: ALU immediate mode
- `alu_out` in BUS_WIDTH: ALU result
- `alu_overflow` in 1: ALU overflow, valid only for ADD/SUB
- `ex_valid` out 1: result available downstream
- `ex_ready` in 1: memory stage accepts
- `ex_result` out BUS_WIDTH: registered ALU result
- `ex_rd` out REG_ADDR_WIDTH: registered destination
- `ex_wb_en` out 1: registered write enable
- `ex_pc` out BUS_WIDTH: registered PC
- `exc_ovf` out 1: overflow exception pending
- `exc_pc` out BUS_WIDTH: PC of the faulting instruction
- `exc_ack` in 1: exception handler acknowledges

## Operation
- Two register slices:
  - OPR holds the operands and control fields.
  - RES holds the result.
- ALU wiring:
  - `alu_in1` = OPR.rs.
  - `alu_in2` = OPR.use_imm ? {16'b0, OPR.imm} : OPR.rt.
  - `alu_imm` = OPR.use_imm.
  - The ALU performs its own immediate extension.
- Advance rules:
  - res_adv = !RES.valid | ex_ready.
  - opr_adv = !OPR.valid | res_adv.
  - `id_ready` = (state==RUN) & opr_adv & !rst.
- Overflow is sampled only when OPR.alu_op is ADD or SUB. For any other op `alu_overflow` is ignored, because the ALU drives X there.
- trap = OPR.valid & OPR.trap_ovf & (op∈{ADD,SUB}) & alu_overflow.
- State machine:
  - RUN → TRAP when trap & res_adv. On that edge:
    - OPR is cleared and RES is not loaded.
    - `exc_ovf`←1 and `exc_pc`←OPR.pc.
    - An older instruction already in RES still drains normally.
  - TRAP → RUN on `exc_ack`. On that edge `exc_ovf`←0.
  - `exc_ack` in RUN is ignored.
  - In TRAP, `id_ready`=0 and OPR stays empty.
- A non-trapping overflow (id_trap_ovf=0) writes the wrapped sum normally.

## Timing
- Latency: an instruction accepted at edge N appears on `ex_valid` after edge N+1.
- Throughput: 1 instruction/cycle while `ex_ready`=1.
- When `ex_ready`=0, RES holds and `ex_*` stay stable. OPR fills, then `id_ready` drops in the same cycle (combinational).
- Simultaneous RES drain and OPR load and input accept in one cycle is legal.
- Reset values:
  - `ex_valid` 0, `ex_result` 0, `ex_rd` 0, `ex_wb_en` 0, `ex_pc` 0.
  - `exc_ovf` 0, `exc_pc` 0.
  - OPR.valid 0; OPR fields 0, so the ALU sees ADD 0,0.
  - state RUN.
- Reset mid-operation or in TRAP discards all in-flight instructions; no exception survives.
- `ex_*` change only on edges where RES loads.

## Structure
- Shared package `mips_pkg`:
  - ALU opcode constants: ADD=5'h00, SUB=5'h10, AND=5'h1, OR=5'h2, NOT=5'h3, XOR=5'h4, SLL=5'h5, SRL=5'h6, SRA=5'h7, EQ=5'h8, NE=5'h9, LT=5'ha, GT=5'hb, LE=5'hc, GE=5'hd, LTU=5'he, GTU=5'hf.
  - The ex_stage state encoding (RUN, TRAP).
- One sub-module: `ex_pipe_reg`, a parameterised valid/ready register slice. It is instantiated for OPR and for RES.
- The ALU is instantiated by the parent, not inside ex_stage.

## Test plan
- Reset then ADD rs=3, rt=4, id_ready=1, ex_ready=1 → ex_valid after 2 edges, ex_result=7, exc_ovf=0.
- ADDI rs=5, imm=16'hFFFF → alu_in2=32'h0000FFFF, alu_imm=1, ex_result=4.
- Back-to-back stream of 8 instructions with ex_ready held 0 for 3 cycles mid-stream → no loss or duplication, order preserved, id_ready low exactly while OPR and RES are both full.
- Trapping ADD 32'h7FFFFFFF+1 with pc=0x40, preceded by a valid instruction → preceding result delivered; exc_ovf=1, exc_pc=0x40; faulting result never on ex_valid; id_ready=0 until exc_ack, then RUN next cycle.
- Same ADD with id_trap_ovf=0 → ex_result=32'h80000000, no exception; SLT op with alu_overflow forced X → no exception.
- rst asserted while in TRAP and with RES full → next cycle ex_valid=0, exc_ovf=0, state RUN.
